// File: rtl/req_resp_engine.sv
// req_resp_engine: single-outstanding request/response responder.
// A request accepted in IDLE is acknowledged on the next cycle and answered
// with a one-cycle valid beat (operand + 1) after a clamped 1..5 cycle latency.
// A request that arrives while busy is dropped and flagged on error one cycle
// later. Every output comes straight from a flop.
// Optional build macro: RESP_PARITY_EN adds the registered data_par output.
module req_resp_engine #(
    parameter int DATA_W  = 8,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        lat_cfg,
    output logic              ack,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              error,
`ifdef RESP_PARITY_EN
    output logic              data_par,
`endif
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [2:0] LAT_LO = 3'(MIN_LAT);
    localparam logic [2:0] LAT_HI = 3'(MAX_LAT);

    // Clamp the requested latency into the supported window.
    function automatic logic [2:0] clamp_lat(input logic [2:0] cfg);
        if (cfg < LAT_LO) begin
            return LAT_LO;
        end else if (cfg > LAT_HI) begin
            return LAT_HI;
        end
        return cfg;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [2:0]        lat_q, lat_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              ack_q, ack_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        op_d    = op_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = req_data;
                    lat_d   = clamp_lat(lat_cfg);
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Counter holds the number of WAIT cycles still to spend.
                cnt_d   = lat_q - 3'd1;
                state_d = (lat_q == 3'd1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of what the next state presents.
        ack_d   = (state_d == ST_ACK);
        valid_d = (state_d == ST_RESP);
        data_d  = valid_d ? (op_q + DATA_W'(1)) : '0;
        busy_d  = (state_d != ST_IDLE);
        // A request seen while busy is dropped; only the flag survives.
        error_d = req && (state_q != ST_IDLE);
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= ST_IDLE;
            op_q    <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    assign ack   = ack_q;
    assign valid = valid_q;
    assign data  = data_q;
    assign error = error_q;
    assign busy  = busy_q;

`ifdef RESP_PARITY_EN
    logic par_q;

    // Even parity of the response beat, registered alongside data.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= valid_d ? ^data_d : 1'b0;
        end
    end

    assign data_par = par_q;
`endif

endmodule

// File: tb/tb_req_resp_engine.sv
// Testbench for req_resp_engine: directed scenarios plus randomized traffic,
// all cross-checked every cycle against a transaction-level reference model.
module tb_req_resp_engine;

    localparam int DATA_W = 8;
    localparam int MAXC   = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic [DATA_W-1:0] req_data;
    logic [2:0]        lat_cfg;
    logic              ack;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              error;
    logic              busy;
`ifdef RESP_PARITY_EN
    logic              data_par;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected outputs per cycle, filled in by the model when a request lands.
    typedef struct packed {
        logic              ack;
        logic              valid;
        logic              error;
        logic              busy;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_tab [MAXC];
    int   idle_at = 0;
    bit   armed   = 1'b0;

    req_resp_engine #(.DATA_W(DATA_W), .MIN_LAT(1), .MAX_LAT(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .lat_cfg  (lat_cfg),
        .ack      (ack),
        .valid    (valid),
        .data     (data),
        .error    (error),
`ifdef RESP_PARITY_EN
        .data_par (data_par),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Transaction-level model: schedule the consequences of cycle t's inputs.
    task automatic model_step(input int t, input logic r, input logic rq,
                              input logic [DATA_W-1:0] d, input logic [2:0] l);
        int lat;
        if (r) begin
            for (int c = t + 1; c < t + 10; c++) exp_tab[c] = '0;
            idle_at = t + 1;
            armed   = 1'b1;
        end else if (rq) begin
            if (t >= idle_at) begin
                lat = int'(l);
                if (lat < 1) lat = 1;
                if (lat > 5) lat = 5;
                exp_tab[t + 1].ack = 1'b1;
                for (int c = t + 1; c <= t + 1 + lat; c++) exp_tab[c].busy = 1'b1;
                exp_tab[t + 1 + lat].valid = 1'b1;
                exp_tab[t + 1 + lat].data  = d + 8'd1;
                idle_at = t + 2 + lat;
            end else begin
                exp_tab[t + 1].error = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the clock, compare against the model.
    task automatic cycle(input logic r, input logic rq,
                         input logic [DATA_W-1:0] d, input logic [2:0] l);
        exp_t e;
        if (cyc >= MAXC - 16) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 16);
            $fatal(1, "cycle budget exhausted");
        end
        rst = r; req = rq; req_data = d; lat_cfg = l;
        model_step(cyc, r, rq, d, l);
        @(posedge clk);
        #1;
        cyc++;
        if (armed) begin
            e = exp_tab[cyc];
            checks++;
            if (ack !== e.ack) begin
                errors++;
                $display("FAIL sb_ack cyc=%0d got=%b exp=%b", cyc, ack, e.ack);
            end
            checks++;
            if (valid !== e.valid) begin
                errors++;
                $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, valid, e.valid);
            end
            checks++;
            if (error !== e.error) begin
                errors++;
                $display("FAIL sb_error cyc=%0d got=%b exp=%b", cyc, error, e.error);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, busy, e.busy);
            end
            if (e.valid) begin
                checks++;
                if (data !== e.data) begin
                    errors++;
                    $display("FAIL sb_data cyc=%0d got=%h exp=%h", cyc, data, e.data);
                end
            end
`ifdef RESP_PARITY_EN
            checks++;
            if (data_par !== (e.valid ? ^e.data : 1'b0)) begin
                errors++;
                $display("FAIL sb_par cyc=%0d got=%b exp=%b", cyc, data_par,
                         (e.valid ? ^e.data : 1'b0));
            end
`endif
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, DATA_W'($urandom), 3'($urandom));
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 8'h00, 3'd0);
        cycle(1'b1, 1'b1, 8'h55, 3'd2);
        checks++;
        if ({ack, valid, error, busy, data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {ack, valid, error, busy, data});
        end
    endtask

    task automatic test_basic();
        cycle(1'b0, 1'b1, 8'h3A, 3'd3);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack got=%b exp=1", ack);
        end
        idle(3);
        checks++;
        if (valid !== 1'b1 || data !== 8'h3B) begin
            errors++;
            $display("FAIL basic_valid got=%b/%h exp=1/3b", valid, data);
        end
        idle(2);
    endtask

    task automatic test_clamp();
        logic [2:0] cfg_tab  [3] = '{3'd0, 3'd7, 3'd5};
        int         dist_tab [3] = '{2, 6, 6};
        int k;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, DATA_W'($urandom), cfg_tab[i]);
            k = 1;
            while (valid !== 1'b1 && k < 12) begin
                idle(1);
                k++;
            end
            checks++;
            if (k !== dist_tab[i]) begin
                errors++;
                $display("FAIL clamp_lat cfg=%0d got=%0d exp=%0d", cfg_tab[i], k, dist_tab[i]);
            end
            idle(2);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 8'hFF, 3'd1);
        idle(1);
        checks++;
        if (valid !== 1'b1 || data !== 8'h00) begin
            errors++;
            $display("FAIL wrap_data got=%b/%h exp=1/00", valid, data);
        end
        idle(2);
`ifdef RESP_PARITY_EN
        cycle(1'b0, 1'b1, 8'h06, 3'd1);
        idle(1);
        checks++;
        if (data !== 8'h07 || data_par !== 1'b1) begin
            errors++;
            $display("FAIL wrap_parity got=%h/%b exp=07/1", data, data_par);
        end
        idle(2);
`endif
    endtask

    task automatic test_busy_violation();
        cycle(1'b0, 1'b1, 8'hC4, 3'd4);
        idle(2);
        cycle(1'b0, 1'b1, 8'h11, 3'd1);
        checks++;
        if (error !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL busy_err got=%b/%b exp=1/0 (error/ack)", error, ack);
        end
        idle(1);
        checks++;
        if (error !== 1'b0 || valid !== 1'b1 || data !== 8'hC5) begin
            errors++;
            $display("FAIL busy_resp got=%b/%b/%h exp=0/1/c5", error, valid, data);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b1, 8'h20, 3'd1);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack1 got=%b exp=1", ack);
        end
        cycle(1'b0, 1'b1, 8'h30, 3'd1);
        checks++;
        if (error !== 1'b1 || valid !== 1'b1 || data !== 8'h21) begin
            errors++;
            $display("FAIL b2b_t2 got=%b/%b/%h exp=1/1/21", error, valid, data);
        end
        cycle(1'b0, 1'b1, 8'h40, 3'd1);
        checks++;
        if (error !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_t3 got=%b/%b exp=1/0 (error/ack)", error, ack);
        end
        cycle(1'b0, 1'b1, 8'h50, 3'd1);
        checks++;
        if (ack !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack2 got=%b/%b exp=1/0 (ack/error)", ack, error);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_op();
        cycle(1'b0, 1'b1, 8'h77, 3'd5);
        idle(2);
        cycle(1'b1, 1'b0, 8'h00, 3'd0);
        checks++;
        if ({ack, valid, error, busy, data} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got=%b exp=0", {ack, valid, error, busy, data});
        end
        idle(1);
        cycle(1'b0, 1'b1, 8'h90, 3'd2);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reaccept got=%b exp=1", ack);
        end
        idle(5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                  DATA_W'($urandom), 3'($urandom));
        end
        idle(8);
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) exp_tab[i] = '0;
        rst = 1'b1; req = 1'b0; req_data = '0; lat_cfg = '0;
        test_reset();
        test_basic();
        test_clamp();
        test_wrap();
        test_busy_violation();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
